// File: rtl/decode_pkg.sv
// Shared decode types and constants for the multi-lane decode queue.
// uop_t carries a 32-bit pc field; narrower PCs are zero-extended.
package decode_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] FU_ALU = 2'b00;
  localparam logic [1:0] FU_BRU = 2'b01;
  localparam logic [1:0] FU_LSU = 2'b10;
  localparam logic [1:0] FU_MDU = 2'b11;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;
  localparam logic [3:0] ALU_AUIPC = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_JAL   = 4'b1110;
  localparam logic [3:0] ALU_JALR  = 4'b1111;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        alu_src;
    logic        branch;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  fu_type;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        illegal;
  } uop_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational RV32I decode of one lane into a uop_t.
// Define DECODE_RV32M_EN to route RV32M encodings to the MDU.
module decode_lane
  import decode_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output uop_t        o_uop,
  output logic        o_lane_valid
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_m;

  assign opc  = i_instr[6:0];
  assign f3   = i_instr[14:12];
  assign f7   = i_instr[31:25];
  assign is_m = (opc == OPC_OP) && (f7 == 7'b0000001);

  assign o_lane_valid = (i_instr != NOP);

  always_comb begin
    o_uop    = '0;
    o_uop.pc = i_pc;
    unique case (1'b1)
      (opc == OPC_LUI): begin
        o_uop.rd        = i_instr[11:7];
        o_uop.imm       = imm_u(i_instr);
        o_uop.alu_src   = 1'b1;
        o_uop.alu_op    = ALU_LUI;
        o_uop.reg_write = 1'b1;
      end
      (opc == OPC_AUIPC): begin
        o_uop.rd        = i_instr[11:7];
        o_uop.imm       = imm_u(i_instr);
        o_uop.alu_src   = 1'b1;
        o_uop.alu_op    = ALU_AUIPC;
        o_uop.reg_write = 1'b1;
      end
      (opc == OPC_JAL): begin
        o_uop.rd        = i_instr[11:7];
        o_uop.imm       = imm_j(i_instr);
        o_uop.branch    = 1'b1;
        o_uop.alu_op    = ALU_JAL;
        o_uop.fu_type   = FU_BRU;
        o_uop.reg_write = 1'b1;
      end
      (opc == OPC_JALR): begin
        o_uop.rs1       = i_instr[19:15];
        o_uop.rd        = i_instr[11:7];
        o_uop.imm       = imm_i(i_instr);
        o_uop.alu_src   = 1'b1;
        o_uop.branch    = 1'b1;
        o_uop.alu_op    = ALU_JALR;
        o_uop.fu_type   = FU_BRU;
        o_uop.reg_write = 1'b1;
      end
      (opc == OPC_BRANCH): begin
        o_uop.rs1     = i_instr[19:15];
        o_uop.rs2     = i_instr[24:20];
        o_uop.imm     = imm_b(i_instr);
        o_uop.branch  = 1'b1;
        o_uop.alu_op  = {1'b0, f3};
        o_uop.fu_type = FU_BRU;
      end
      (opc == OPC_LOAD): begin
        o_uop.rs1       = i_instr[19:15];
        o_uop.rd        = i_instr[11:7];
        o_uop.imm       = imm_i(i_instr);
        o_uop.alu_src   = 1'b1;
        o_uop.alu_op    = {1'b0, f3};
        o_uop.fu_type   = FU_LSU;
        o_uop.mem_read  = 1'b1;
        o_uop.reg_write = 1'b1;
      end
      (opc == OPC_STORE): begin
        o_uop.rs1       = i_instr[19:15];
        o_uop.rs2       = i_instr[24:20];
        o_uop.imm       = imm_s(i_instr);
        o_uop.alu_src   = 1'b1;
        o_uop.alu_op    = {1'b0, f3};
        o_uop.fu_type   = FU_LSU;
        o_uop.mem_write = 1'b1;
      end
      (opc == OPC_OPIMM): begin
        o_uop.rs1       = i_instr[19:15];
        o_uop.rd        = i_instr[11:7];
        o_uop.imm       = imm_i(i_instr);
        o_uop.alu_src   = 1'b1;
        o_uop.alu_op    = {(f3 == 3'b101) & i_instr[30], f3};
        o_uop.reg_write = 1'b1;
      end
      (opc == OPC_OP) && !is_m: begin
        o_uop.rs1       = i_instr[19:15];
        o_uop.rs2       = i_instr[24:20];
        o_uop.rd        = i_instr[11:7];
        o_uop.alu_op    = {i_instr[30], f3};
        o_uop.reg_write = 1'b1;
      end
`ifdef DECODE_RV32M_EN
      is_m: begin
        o_uop.rs1       = i_instr[19:15];
        o_uop.rs2       = i_instr[24:20];
        o_uop.rd        = i_instr[11:7];
        o_uop.alu_op    = {1'b0, f3};
        o_uop.fu_type   = FU_MDU;
        o_uop.reg_write = 1'b1;
      end
`endif
      default: o_uop.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_decode_queue.sv
// LANES-wide decoder feeding a DEPTH-entry queue of decoded bundles.
// Build with DECODE_RV32M_EN to decode RV32M ops into the MDU.
module multi_decode_queue
  import decode_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 2,
  parameter int PC_W  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [LANES-1:0][31:0] i_instr,
  input  logic [PC_W-1:0]       i_pc,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [LANES-1:0]      o_lane_valid,
  output uop_t [LANES-1:0]      o_uop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  uop_t [LANES-1:0] dec_uop;
  logic [LANES-1:0] dec_lv;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [PC_W-1:0] lane_pc;
    assign lane_pc = i_pc + PC_W'(4 * k);
    decode_lane u_dec (
      .i_instr      (i_instr[k]),
      .i_pc         (32'(lane_pc)),
      .o_uop        (dec_uop[k]),
      .o_lane_valid (dec_lv[k])
    );
  end

  uop_t [LANES-1:0] q_uop [DEPTH];
  logic [LANES-1:0] q_lv  [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_valid = (count != '0);
  assign o_ready = (count < CNT_W'(DEPTH)) || (o_valid && i_ready);
  // All-NOP bundles are accepted but never occupy an entry.
  assign push = i_valid && o_ready && !i_flush && (|dec_lv);
  assign pop  = o_valid && i_ready && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (i_flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_uop[tail] <= dec_uop;
      q_lv[tail]  <= dec_lv;
    end
  end

  assign o_uop        = o_valid ? q_uop[head] : '0;
  assign o_lane_valid = o_valid ? q_lv[head]  : '0;

endmodule

// File: tb/tb_multi_decode_queue.sv
// Directed and randomized checks of multi_decode_queue against a
// queue-based reference model with its own RV32I decode rules.
module tb_multi_decode_queue;
  import decode_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 2;
  localparam int PC_W  = 9;

  typedef struct packed {
    logic [LANES-1:0] lv;
    uop_t [LANES-1:0] u;
  } bundle_t;

  logic                   clk;
  logic                   rst_n;
  logic                   i_valid;
  logic                   o_ready;
  logic [LANES-1:0][31:0] i_instr;
  logic [PC_W-1:0]        i_pc;
  logic                   i_flush;
  logic                   o_valid;
  logic                   i_ready;
  logic [LANES-1:0]       o_lane_valid;
  uop_t [LANES-1:0]       o_uop;

  int checks = 0;
  int errors = 0;
  bundle_t mq[$];

  multi_decode_queue #(.LANES(LANES), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_instr      (i_instr),
    .i_pc         (i_pc),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_lane_valid (o_lane_valid),
    .o_uop        (o_uop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic uop_t ref_uop(input logic [31:0] ins, input int pc);
    uop_t u;
    int   sim;
    logic [2:0] f3;
    u = '0;
    u.pc = 32'(pc);
    f3 = ins[14:12];
    case (ins[6:0])
      7'h37, 7'h17: begin
        u.rd = ins[11:7];
        u.imm = ins & 32'hFFFF_F000;
        u.alu_src = 1;
        u.reg_write = 1;
        u.alu_op = (ins[6:0] == 7'h37) ? 4'd9 : 4'd10;
      end
      7'h6f: begin
        sim = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
        u.rd = ins[11:7];
        u.imm = 32'(sim);
        u.branch = 1;
        u.reg_write = 1;
        u.fu_type = 2'd1;
        u.alu_op = 4'd14;
      end
      7'h67: begin
        u.rs1 = ins[19:15];
        u.rd = ins[11:7];
        u.imm = 32'(int'($signed(ins[31:20])));
        u.alu_src = 1;
        u.branch = 1;
        u.reg_write = 1;
        u.fu_type = 2'd1;
        u.alu_op = 4'd15;
      end
      7'h63: begin
        sim = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
        u.rs1 = ins[19:15];
        u.rs2 = ins[24:20];
        u.imm = 32'(sim);
        u.branch = 1;
        u.fu_type = 2'd1;
        u.alu_op = {1'b0, f3};
      end
      7'h03: begin
        u.rs1 = ins[19:15];
        u.rd = ins[11:7];
        u.imm = 32'(int'($signed(ins[31:20])));
        u.alu_src = 1;
        u.mem_read = 1;
        u.reg_write = 1;
        u.fu_type = 2'd2;
        u.alu_op = {1'b0, f3};
      end
      7'h23: begin
        u.rs1 = ins[19:15];
        u.rs2 = ins[24:20];
        u.imm = 32'(int'($signed({ins[31:25], ins[11:7]})));
        u.alu_src = 1;
        u.mem_write = 1;
        u.fu_type = 2'd2;
        u.alu_op = {1'b0, f3};
      end
      7'h13: begin
        u.rs1 = ins[19:15];
        u.rd = ins[11:7];
        u.imm = 32'(int'($signed(ins[31:20])));
        u.alu_src = 1;
        u.reg_write = 1;
        u.alu_op = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
      end
      7'h33: begin
        if (ins[31:25] == 7'd1) begin
`ifdef DECODE_RV32M_EN
          u.rs1 = ins[19:15];
          u.rs2 = ins[24:20];
          u.rd = ins[11:7];
          u.reg_write = 1;
          u.fu_type = 2'd3;
          u.alu_op = {1'b0, f3};
`else
          u.illegal = 1;
`endif
        end else begin
          u.rs1 = ins[19:15];
          u.rs2 = ins[24:20];
          u.rd = ins[11:7];
          u.reg_write = 1;
          u.alu_op = {ins[30], f3};
        end
      end
      default: u.illegal = 1;
    endcase
    return u;
  endfunction

  function automatic bundle_t ref_bundle();
    bundle_t b;
    for (int k = 0; k < LANES; k++) begin
      b.u[k]  = ref_uop(i_instr[k], (int'(i_pc) + 4 * k) % (1 << PC_W));
      b.lv[k] = (i_instr[k] != 32'h0000_0013);
    end
    return b;
  endfunction

  task automatic model_check();
    bundle_t b;
    logic    ev, er;
    #1;
    b  = (mq.size() != 0) ? mq[0] : '0;
    ev = (mq.size() != 0);
    er = (mq.size() < DEPTH) || (ev && i_ready);
    chk("o_valid", o_valid, ev);
    chk("o_ready", o_ready, er);
    chk("o_lane_valid", o_lane_valid, b.lv);
    chk("o_uop", o_uop, b.u);
  endtask

  task automatic model_step();
    bundle_t b;
    logic    ev, er;
    b  = ref_bundle();
    ev = (mq.size() != 0);
    er = (mq.size() < DEPTH) || (ev && i_ready);
    if (!rst_n || i_flush) begin
      mq.delete();
    end else begin
      if (ev && i_ready) void'(mq.pop_front());
      if (i_valid && er && (b.lv != '0)) mq.push_back(b);
    end
  endtask

  task automatic tick();
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [PC_W-1:0] pc,
                       input logic rdy, input logic fl);
    i_valid    = v;
    i_instr[0] = a;
    i_instr[1] = b;
    i_pc       = pc;
    i_ready    = rdy;
    i_flush    = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:  return {r[31:7], 7'h37};
      1:  return {r[31:7], 7'h17};
      2:  return {r[31:7], 7'h6f};
      3:  return {r[31:15], 3'b000, r[11:7], 7'h67};
      4:  return {r[31:7], 7'h63};
      5:  return {r[31:7], 7'h03};
      6:  return {r[31:7], 7'h23};
      7:  return {r[31:7], 7'h13};
      8:  return {(r[0] ? 7'h20 : 7'h00), r[24:7], 7'h33};
      9:  return {7'h01, r[24:7], 7'h33};
      10: return 32'h0000_0013;
      default: return {r[31:7], 7'h7f};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_lane_valid", o_lane_valid, 2'b00);
    chk("rst_o_uop", o_uop, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", o_ready, 1'b1);

    // ADDI / SUB pair appears one cycle after acceptance
    drive(1, 32'h0050_0093, 32'h4020_8133, 9'h010, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("addi_valid", o_valid, 1'b1);
    chk("addi_lanes", o_lane_valid, 2'b11);
    chk("addi_rd", o_uop[0].rd, 5'd1);
    chk("addi_imm", o_uop[0].imm, 32'd5);
    chk("addi_pc", o_uop[0].pc, 32'h010);
    chk("addi_aluop", o_uop[0].alu_op, 4'b0000);
    chk("sub_rd", o_uop[1].rd, 5'd2);
    chk("sub_pc", o_uop[1].pc, 32'h014);
    chk("sub_aluop", o_uop[1].alu_op, 4'b1000);
    i_ready = 1;
    tick();

    // all-NOP bundle is consumed, never enqueued
    drive(1, 32'h13, 32'h13, 9'h020, 1, 0);
    #1;
    chk("nop_ready", o_ready, 1'b1);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    #1;
    chk("nop_no_valid", o_valid, 1'b0);
    tick();

    // fill, stall, then push+pop while full
    drive(1, 32'h0010_0093, 32'h0020_0113, 9'h040, 0, 0);
    tick();
    drive(1, 32'h0030_0193, 32'h0040_0213, 9'h080, 0, 0);
    tick();
    drive(1, 32'h0050_0293, 32'h0060_0313, 9'h0C0, 0, 0);
    #1;
    chk("full_not_ready", o_ready, 1'b0);
    tick();
    i_ready = 1;
    #1;
    chk("full_pop_ready", o_ready, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("full_still", o_ready, 1'b0);
    chk("full_head_pc", o_uop[0].pc, 32'h080);
    tick();

    // flush while full with a pending push
    drive(1, 32'h0070_0393, 32'h0080_0413, 9'h100, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("flush_valid", o_valid, 1'b0);
    drive(1, 32'h0090_0493, 32'h13, 9'h140, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("post_flush_valid", o_valid, 1'b1);
    chk("post_flush_ready", o_ready, 1'b1);
    i_ready = 1;
    tick();
    #1;
    chk("post_flush_count1", o_valid, 1'b0);

    // lane pc wraps modulo 2^PC_W
    drive(1, 32'h0010_0093, 32'h0020_0113, 9'h1FC, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_pc0", o_uop[0].pc, 32'h1FC);
    chk("wrap_pc1", o_uop[1].pc, 32'h000);
    i_ready = 1;
    tick();

    // RV32M encoding depends on the build
    drive(1, 32'h0220_8033, 32'h13, 9'h010, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("m_lanes", o_lane_valid, 2'b01);
`ifdef DECODE_RV32M_EN
    chk("m_futype", o_uop[0].fu_type, 2'b11);
    chk("m_illegal", o_uop[0].illegal, 1'b0);
    chk("m_regwrite", o_uop[0].reg_write, 1'b1);
`else
    chk("m_illegal", o_uop[0].illegal, 1'b1);
    chk("m_futype", o_uop[0].fu_type, 2'b00);
    chk("m_regwrite", o_uop[0].reg_write, 1'b0);
`endif
    i_ready = 1;
    tick();

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), rand_instr(),
            PC_W'($urandom), $urandom_range(0, 4) < 3,
            $urandom_range(0, 24) == 0);
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        mq.delete();
        chk("async_rst_valid", o_valid, 1'b0);
        chk("async_rst_lanes", o_lane_valid, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_decode_queue.md
MULTI_DECODE_QUEUE -- requirements
Module: multi_decode_queue

Interface
REQ-001 SHALL have parameter LANES, default 2, the number of instructions decoded per bundle (1..4).
REQ-002 SHALL have parameter DEPTH, default 2, the number of decoded-bundle queue entries (>=1, any integer).
REQ-003 SHALL have parameter PC_W, default 9, the PC width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port i_valid, input, 1 bit: the upstream bundle is valid.
REQ-007 SHALL have port o_ready, output, 1 bit: this block accepts a bundle this cycle.
REQ-008 SHALL have port i_instr, input, LANES x 32 bits: raw instructions, with lane 0 the oldest.
REQ-009 SHALL have port i_pc, input, PC_W bits: the PC of lane 0.
REQ-010 SHALL have port i_flush, input, 1 bit: discard all queued and incoming bundles.
REQ-011 SHALL have port o_valid, output, 1 bit: the head bundle is valid.
REQ-012 SHALL have port i_ready, input, 1 bit: downstream pops the head bundle.
REQ-013 SHALL have port o_lane_valid, output, LANES bits: per-lane valid for the head bundle.
REQ-014 SHALL have port o_uop, output, LANES x uop_t: per-lane decoded fields {pc, rs1, rs2, rd, ALUsrc, Branch, imm, ALUOp, FUtype, Memread, Memwrite, Regwrite, illegal}.

Function
REQ-015 SHALL compute lane k PC as i_pc + 4*k, modulo 2^PC_W.
REQ-016 SHALL decode each lane with the RV32I field, immediate, ALUOp and FUtype encoding in force (ALU=00, BRU=01, LSU=10); loads, stores and branches carry {0,funct3} in ALUOp.
REQ-017 SHALL decode an unrecognised opcode as illegal=1, lane valid, with all other control fields zero.
REQ-018 SHALL clear a lane's valid bit when that lane holds 0x00000013.
REQ-019 SHALL accept a bundle when i_valid && o_ready && !i_flush.
REQ-020 SHALL consume an accepted bundle whose lanes are all NOP without enqueuing it.
REQ-021 SHALL drive o_ready = (count < DEPTH) || (o_valid && i_ready).
REQ-022 SHALL, on a bundle accepted at edge N, present that bundle on the outputs after edge N when the queue was empty: latency 1, no combinational input-to-output path.
REQ-023 SHALL drive o_valid = (count != 0); pop occurs on o_valid && i_ready.
REQ-024 SHALL, on simultaneous push and pop, leave count unchanged; when full, that push SHALL succeed.
REQ-025 SHALL wrap head and tail pointers from DEPTH-1 to 0.
REQ-026 SHALL, on i_flush, zero count and pointers at the next edge and ignore the same-cycle push and pop; o_valid is 0 in the following cycle.
REQ-027 SHALL drive o_uop and o_lane_valid to zero whenever o_valid=0.
REQ-028 SHALL keep the head bundle stable while o_valid && !i_ready.

Reset
REQ-029 SHALL, on rst_n low and asynchronously, force count=0, pointers=0, o_valid=0 and o_lane_valid=0.
REQ-030 SHALL drive o_ready=1 one cycle after reset release and discard any in-flight bundle.
REQ-031 SHALL handle reset mid-transfer identically to REQ-029; queue storage contents need not be cleared.

Configuration
REQ-032 SHALL, with DECODE_RV32M_EN defined, decode opcode 0110011 with funct7=0000001 as FUtype=11 (MDU), ALUOp={0,funct3}, Regwrite=1, illegal=0.
REQ-033 SHALL, without DECODE_RV32M_EN, decode the same encoding as illegal=1, FUtype=00 and Regwrite=0.

Structure
REQ-034 SHALL place uop_t, the ALU_* opcode constants, the FU_* codes and the NOP constant in the shared package decode_pkg.
REQ-035 SHALL implement per-lane combinational decode in sub-module decode_lane, instantiated LANES times.

Verification
REQ-036 SHALL cover: LANES=2, with i_instr={0x00500093, 0x40208133} at pc 0x010 -> one cycle later o_valid=1; lane0 is ADDI rd=1 imm=5 pc=0x010; lane1 is SUB rd=2 pc=0x014.
REQ-037 SHALL cover: a bundle {0x00000013, 0x00000013} -> o_ready=1, nothing enqueued, o_valid stays 0.
REQ-038 SHALL cover: DEPTH=2 with i_ready=0 and three pushes -> o_ready=0 after the second push; with i_ready=1 and i_valid=1 in the same cycle, the push succeeds and count stays 2.
REQ-039 SHALL cover: i_flush with the queue full and i_valid=1 -> o_valid=0 next cycle; the subsequent bundle appears with count=1.
REQ-040 SHALL cover: i_pc=0x1FC with LANES=2 -> lane1 pc=0x000.
REQ-041 SHALL cover: instruction 0x02208033 -> FUtype=11 with DECODE_RV32M_EN defined, and illegal=1 without it.
